// File: rtl/mem_mux_rr_pkg.sv
// ============================================================================
// Module      : mem_mux_rr_pkg
// Description : Shared helper for the mem_mux_rr read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_mux_rr_pkg;

    // Width of a tag (or pointer) able to name n distinct items; never below 1.
    function automatic int mem_mux_tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_mux_rr_tag_fifo.sv
// ============================================================================
// Module      : mem_mux_rr_tag_fifo
// Description : Register FIFO of source tags for reads in flight, with count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_mux_rr_tag_fifo
    import mem_mux_rr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [TAG_W-1:0]             push_tag,
    input  logic                         pop,
    output logic [TAG_W-1:0]             head_tag,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = mem_mux_tag_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last_ptr) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign head_tag = r_mem[r_rd_ptr];
    assign count    = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_tag;
    end

endmodule

`default_nettype wire

// File: rtl/mem_mux_rr.sv
// ============================================================================
// Module      : mem_mux_rr
// Description : NUM_SRC-source round-robin read mux for one state memory, with
//               in-order response steering through a tag FIFO.
//               Optional macro MEM_MUX_RR_PRIO0_EN gives src 0 strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_mux_rr
    import mem_mux_rr_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SRC-1:0]                    src_rd_req_val,
    input  logic [NUM_SRC*ADDR_W-1:0]             src_rd_req_addr,
    output logic [NUM_SRC-1:0]                    src_rd_req_rdy,
    output logic [NUM_SRC-1:0]                    src_rd_resp_val,
    output logic [DATA_W-1:0]                     src_rd_resp_data,
    input  logic [NUM_SRC-1:0]                    src_rd_resp_rdy,
    output logic                                  dst_rd_req_val,
    output logic [ADDR_W-1:0]                     dst_rd_req_addr,
    input  logic                                  dst_rd_req_rdy,
    input  logic                                  dst_rd_resp_val,
    input  logic [DATA_W-1:0]                     dst_rd_resp_data,
    output logic                                  dst_rd_resp_rdy,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_cnt
);

    localparam int SRC_W = mem_mux_tag_w(NUM_SRC);

`ifdef MEM_MUX_RR_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic [SRC_W-1:0]  r_last_grant;
    logic [SRC_W-1:0]  r_lock_grant;
    logic              r_lock;
    logic [SRC_W-1:0]  w_rr_grant;
    logic              w_rr_found;
    logic [SRC_W-1:0]  w_grant;
    logic [ADDR_W-1:0] w_addr;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [SRC_W-1:0]  w_head;

    // Round-robin search starting just past the last granted source.
    always_comb begin
        int idx;
        idx        = 0;
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_SRC;
            if (!w_rr_found && src_rd_req_val[SRC_W'(idx)] && !(PRIO0 && idx == 0)) begin
                w_rr_grant = SRC_W'(idx);
                w_rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        if (r_lock && src_rd_req_val[r_lock_grant]) w_grant = r_lock_grant;
        else if (PRIO0 && src_rd_req_val[0])       w_grant = '0;
        else                                       w_grant = w_rr_grant;
    end

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant == SRC_W'(i)) w_addr = src_rd_req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Full blocks issue outright; a pop in the same cycle is not forwarded.
    assign w_issue = (|src_rd_req_val) & ~w_full;
    assign w_push  = w_issue & dst_rd_req_rdy;
    assign w_pop   = dst_rd_resp_val & ~w_empty & src_rd_resp_rdy[w_head];

    assign dst_rd_req_val   = rst & w_issue;
    assign dst_rd_req_addr  = w_addr;
    assign dst_rd_resp_rdy  = rst & ~w_empty & src_rd_resp_rdy[w_head];
    assign src_rd_resp_data = dst_rd_resp_data;

    always_comb begin
        src_rd_req_rdy  = '0;
        src_rd_resp_val = '0;
        if (rst && w_push)                       src_rd_req_rdy[w_grant] = 1'b1;
        if (rst && dst_rd_resp_val && !w_empty)  src_rd_resp_val[w_head] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= SRC_W'(NUM_SRC - 1);
            r_lock       <= 1'b0;
            r_lock_grant <= '0;
        end else begin
            if (w_push && !(PRIO0 && w_grant == '0)) r_last_grant <= w_grant;
            r_lock       <= w_issue & ~dst_rd_req_rdy;
            r_lock_grant <= w_grant;
        end
    end

    mem_mux_rr_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (SRC_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_tag (w_grant),
        .pop      (w_pop),
        .head_tag (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (outstanding_cnt)
    );

`ifndef SYNTHESIS
    a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst) !(dst_rd_resp_val && w_empty));
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_mux_rr.sv
// ============================================================================
// Module      : tb_mem_mux_rr
// Description : Self-checking bench for mem_mux_rr with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_mux_rr;

    localparam int NS = 4;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    src_rd_req_val;
    logic [NS*AW-1:0] src_rd_req_addr;
    logic [NS-1:0]    src_rd_req_rdy;
    logic [NS-1:0]    src_rd_resp_val;
    logic [DW-1:0]    src_rd_resp_data;
    logic [NS-1:0]    src_rd_resp_rdy;
    logic             dst_rd_req_val;
    logic [AW-1:0]    dst_rd_req_addr;
    logic             dst_rd_req_rdy;
    logic             dst_rd_resp_val;
    logic [DW-1:0]    dst_rd_resp_data;
    logic             dst_rd_resp_rdy;
    logic [CW-1:0]    outstanding_cnt;

    always #5 clk = ~clk;

    mem_mux_rr #(
        .NUM_SRC (NS), .ADDR_W (AW), .DATA_W (DW), .MAX_OUTSTANDING (MO)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .src_rd_req_val   (src_rd_req_val),
        .src_rd_req_addr  (src_rd_req_addr),
        .src_rd_req_rdy   (src_rd_req_rdy),
        .src_rd_resp_val  (src_rd_resp_val),
        .src_rd_resp_data (src_rd_resp_data),
        .src_rd_resp_rdy  (src_rd_resp_rdy),
        .dst_rd_req_val   (dst_rd_req_val),
        .dst_rd_req_addr  (dst_rd_req_addr),
        .dst_rd_req_rdy   (dst_rd_req_rdy),
        .dst_rd_resp_val  (dst_rd_resp_val),
        .dst_rd_resp_data (dst_rd_resp_data),
        .dst_rd_resp_rdy  (dst_rd_resp_rdy),
        .outstanding_cnt  (outstanding_cnt)
    );

    int            n_chk;
    int            n_pass;
    bit            mem_en;
    logic [NS-1:0] hs_last;
    int            m_last;
    bit            m_lock;
    int            m_lock_src;
    int            m_q[$];
    logic [AW-1:0] mem_q[$];
    logic [AW-1:0] sb[NS][$];

    typedef struct {
        int            grant;
        logic [NS-1:0] resp;
        int            cnt;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {8{a}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [AW-1:0] a_of(input int i);
        return src_rd_req_addr[i*AW +: AW];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        src_rd_req_addr[i*AW +: AW] = a;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic reset_model();
        m_last = NS - 1;
        m_lock = 1'b0;
        m_lock_src = 0;
        m_q.delete();
        mem_q.delete();
        for (int i = 0; i < NS; i++) sb[i].delete();
    endtask

    // The memory answers oldest-first whenever enabled and something is pending.
    task automatic drive_mem();
        dst_rd_resp_val  = mem_en && (mem_q.size() > 0);
        dst_rd_resp_data = (mem_q.size() > 0) ? mdata(mem_q[0]) : '0;
    endtask

    function automatic int exp_grant();
        int s;
        if (m_lock && src_rd_req_val[m_lock_src]) return m_lock_src;
`ifdef MEM_MUX_RR_PRIO0_EN
        if (src_rd_req_val[0]) return 0;
`endif
        for (int k = 1; k <= NS; k++) begin
            s = (m_last + k) % NS;
`ifdef MEM_MUX_RR_PRIO0_EN
            if (s == 0) continue;
`endif
            if (src_rd_req_val[s]) return s;
        end
        return -1;
    endfunction

    // One clock: compare outputs mid-cycle, then advance model and environment.
    task automatic step();
        int            g;
        int            h;
        bit            e_dval;
        bit            e_drr;
        bit            push;
        bit            pop;
        bit            req_hs;
        bit            resp_hs;
        logic [AW-1:0] req_addr;
        logic [AW-1:0] ea;
        logic [NS-1:0] e_rdy;
        logic [NS-1:0] e_rv;
        logic [NS-1:0] src_hs;
        drive_mem();
        @(negedge clk);
        g      = exp_grant();
        e_dval = (src_rd_req_val != '0) && (m_q.size() < MO);
        e_rdy  = '0;
        if (e_dval && dst_rd_req_rdy) e_rdy[g] = 1'b1;
        e_rv  = '0;
        e_drr = 1'b0;
        h     = 0;
        if (m_q.size() > 0) begin
            h     = m_q[0];
            e_drr = src_rd_resp_rdy[h];
            if (dst_rd_resp_val) e_rv[h] = 1'b1;
        end
        chk("dst_req_val", dst_rd_req_val, e_dval);
        if (e_dval) chk("dst_req_addr", dst_rd_req_addr, a_of(g));
        chk("src_req_rdy", src_rd_req_rdy, e_rdy);
        chk("src_resp_val", src_rd_resp_val, e_rv);
        chk("dst_resp_rdy", dst_rd_resp_rdy, e_drr);
        chk("resp_data_pass", src_rd_resp_data, dst_rd_resp_data);
        chk("outstanding_cnt", outstanding_cnt, m_q.size());
        for (int i = 0; i < NS; i++) begin
            if (src_rd_resp_val[i] && src_rd_resp_rdy[i]) begin
                chk("resp_has_pending", sb[i].size() > 0, 1'b1);
                if (sb[i].size() > 0) begin
                    ea = sb[i].pop_front();
                    chk("resp_own_data", src_rd_resp_data, mdata(ea));
                end
            end
        end
        src_hs   = src_rd_req_val & src_rd_req_rdy;
        req_hs   = dst_rd_req_val && dst_rd_req_rdy;
        req_addr = dst_rd_req_addr;
        resp_hs  = dst_rd_resp_val && dst_rd_resp_rdy;
        push     = e_dval && dst_rd_req_rdy;
        pop      = (e_rv != '0) && e_drr;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(g);
`ifdef MEM_MUX_RR_PRIO0_EN
            if (g != 0) m_last = g;
`else
            m_last = g;
`endif
        end
        m_lock     = e_dval && !dst_rd_req_rdy;
        m_lock_src = g;
        if (resp_hs && mem_q.size() > 0) void'(mem_q.pop_front());
        if (req_hs) mem_q.push_back(req_addr);
        for (int i = 0; i < NS; i++) if (src_hs[i]) sb[i].push_back(a_of(i));
        hs_last = src_hs;
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        src_rd_req_val  = '0;
        src_rd_resp_rdy = '1;
        mem_en          = 1'b1;
        while (m_q.size() > 0 && t < 40) begin
            step();
            t++;
        end
        chk("drain_left", m_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NS-1:0] first;
        logic [NS-1:0] expv;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        src_rd_req_val = '0;
        src_rd_req_addr = '0;
        src_rd_resp_rdy = '1;
        dst_rd_req_rdy = 1'b0;
        dst_rd_resp_val = 1'b0;
        dst_rd_resp_data = '0;
        mem_en = 1'b0;
        hs_last = '0;
        reset_model();

`ifdef MEM_MUX_RR_PRIO0_EN
        tbl[0] = '{0, 4'b0000, 0};
        tbl[1] = '{0, 4'b0001, 1};
        tbl[2] = '{0, 4'b0001, 1};
        tbl[3] = '{0, 4'b0001, 1};
        tbl[4] = '{0, 4'b0001, 1};
`else
        tbl[0] = '{0, 4'b0000, 0};
        tbl[1] = '{1, 4'b0001, 1};
        tbl[2] = '{2, 4'b0010, 1};
        tbl[3] = '{3, 4'b0100, 1};
        tbl[4] = '{0, 4'b1000, 1};
`endif

        // Reset state: all val/rdy outputs low even with inputs asserted.
        repeat (2) @(posedge clk);
        #1;
        src_rd_req_val = '1;
        dst_rd_req_rdy = 1'b1;
        dst_rd_resp_val = 1'b1;
        #1;
        chk("rst_dst_req_val", dst_rd_req_val, 1'b0);
        chk("rst_src_req_rdy", src_rd_req_rdy, 4'b0000);
        chk("rst_src_resp_val", src_rd_resp_val, 4'b0000);
        chk("rst_dst_resp_rdy", dst_rd_resp_rdy, 1'b0);
        chk("rst_cnt", outstanding_cnt, 0);
        dst_rd_resp_val = 1'b0;
        rst = 1'b1;

        // All sources valid, memory latency 1: table of expected grants/responses.
        for (int i = 0; i < NS; i++) set_addr(i, 8'h20 + 8'(i));
        src_rd_req_val = '1;
        src_rd_resp_rdy = '1;
        mem_en = 1'b1;
        foreach (tbl[k]) begin
            drive_mem();
            #1;
            chk("t1_addr", dst_rd_req_addr, a_of(tbl[k].grant));
            chk("t1_resp_val", src_rd_resp_val, tbl[k].resp);
            chk("t1_cnt", outstanding_cnt, tbl[k].cnt);
            step();
        end
        drain();

        // Grant lock: src2 stalled, src0 arriving must not steal the address.
        set_addr(2, 8'hA2);
        set_addr(0, 8'hA0);
        src_rd_req_val = 4'b0100;
        dst_rd_req_rdy = 1'b0;
        mem_en = 1'b0;
        repeat (3) begin
            #1;
            chk("t2_hold_addr", dst_rd_req_addr, 8'hA2);
            step();
        end
        src_rd_req_val = 4'b0101;
        repeat (2) begin
            #1;
            chk("t2_locked_addr", dst_rd_req_addr, 8'hA2);
            step();
        end
        dst_rd_req_rdy = 1'b1;
        #1;
        chk("t2_hs_to_src2", src_rd_req_rdy, 4'b0100);
        step();
        src_rd_req_val = 4'b0001;
        step();
        drain();

        // Tag FIFO full: issue stops at MO and no same-cycle bypass on pop.
        src_rd_req_val = '1;
        dst_rd_req_rdy = 1'b1;
        mem_en = 1'b0;
        repeat (MO) step();
        chk("t3_cnt_full", outstanding_cnt, MO);
        chk("t3_blocked", dst_rd_req_val, 1'b0);
        mem_en = 1'b1;
        drive_mem();
        #1;
        chk("t3_resp_rdy", dst_rd_resp_rdy, 1'b1);
        chk("t3_no_bypass", dst_rd_req_val, 1'b0);
        step();
        mem_en = 1'b0;
        chk("t3_cnt_after_pop", outstanding_cnt, MO - 1);
        chk("t3_issue_next", dst_rd_req_val, 1'b1);
        step();
        drain();

        // Response backpressure on head tag 1, then in-order release.
        set_addr(1, 8'h51);
        set_addr(3, 8'h53);
        dst_rd_req_rdy = 1'b1;
        mem_en = 1'b0;
        src_rd_req_val = 4'b0010;
        step();
        src_rd_req_val = 4'b1000;
        step();
        src_rd_req_val = '0;
        src_rd_resp_rdy = 4'b1101;
        mem_en = 1'b1;
        repeat (4) begin
            drive_mem();
            #1;
            chk("t4_dst_resp_rdy", dst_rd_resp_rdy, 1'b0);
            chk("t4_resp_val", src_rd_resp_val, 4'b0010);
            chk("t4_data_held", src_rd_resp_data, mdata(8'h51));
            step();
        end
        src_rd_resp_rdy = '1;
        step();
        drive_mem();
        #1;
        chk("t4_next_in_order", src_rd_resp_val, 4'b1000);
        chk("t4_next_data", src_rd_resp_data, mdata(8'h53));
        step();
        drain();

`ifdef MEM_MUX_RR_PRIO0_EN
        // Strict priority for src0, then src1/src2 alternate.
        src_rd_req_val = 4'b0111;
        dst_rd_req_rdy = 1'b1;
        mem_en = 1'b1;
        repeat (4) begin
            #1;
            chk("t5_prio0", src_rd_req_rdy, 4'b0001);
            step();
        end
        src_rd_req_val = 4'b0110;
        #1;
        first = src_rd_req_rdy;
        chk("t5_first_is_1_or_2", (first == 4'b0010) || (first == 4'b0100), 1'b1);
        expv = first;
        repeat (4) begin
            #1;
            chk("t5_alternate", src_rd_req_rdy, expv);
            step();
            expv = (expv == 4'b0010) ? 4'b0100 : 4'b0010;
        end
        drain();
`endif

        // Randomized traffic against the model; sources hold requests until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (!src_rd_req_val[i] || hs_last[i]) begin
                    src_rd_req_val[i] = ($urandom_range(0, 1) == 1);
                    set_addr(i, 8'($urandom));
                end
            end
            dst_rd_req_rdy  = ($urandom_range(0, 9) < 7);
            src_rd_resp_rdy = 4'($urandom) | 4'($urandom);
            mem_en          = ($urandom_range(0, 9) < 6);
            step();
        end
        drain();

        // Reset with three reads in flight.
        for (int i = 0; i < NS; i++) set_addr(i, 8'h70 + 8'(i));
        src_rd_req_val = 4'b0111;
        dst_rd_req_rdy = 1'b1;
        mem_en = 1'b0;
        repeat (3) step();
        chk("t6_inflight", outstanding_cnt, 3);
        src_rd_req_val = '1;
        dst_rd_resp_val = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("t6_cnt_cleared", outstanding_cnt, 0);
        chk("t6_dst_req_val", dst_rd_req_val, 1'b0);
        chk("t6_src_req_rdy", src_rd_req_rdy, 4'b0000);
        chk("t6_src_resp_val", src_rd_resp_val, 4'b0000);
        chk("t6_dst_resp_rdy", dst_rd_resp_rdy, 1'b0);
        reset_model();
        dst_rd_resp_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_first_grant_addr", dst_rd_req_addr, a_of(0));
        chk("t6_first_grant_rdy", src_rd_req_rdy, 4'b0001);
        mem_en = 1'b1;
        repeat (4) step();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
